// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if: operand/result bundle for the ripple-carry adder.
//   master: drives in_valid, a, b, cin; receives out_valid, sum, cout, ovf.
//   slave : receives in_valid, a, b, cin; drives out_valid, sum, cout, ovf.
//   WIDTH must match the WIDTH of the attached adder.
interface ripple_carry_adder_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (output in_valid, a, b, cin, input out_valid, sum, cout, ovf);
   modport slave (input in_valid, a, b, cin, output out_valid, sum, cout, ovf);
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit ripple-carry adder with registered sum/cout/ovf.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all registers
//   rca_io : slave side of ripple_carry_adder_if
//            in_valid/a/b/cin in, out_valid/sum/cout/ovf out
//   Define RCA_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module ripple_carry_adder #(
   parameter int WIDTH = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   ripple_carry_adder_if.slave rca_io
);
   logic             vld;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
`ifdef RCA_INPUT_REG_EN
   logic             vld_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   // Operands load only on valid so X on idle cycles never enters the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else begin
         vld_q <= rca_io.in_valid;
         if (rca_io.in_valid) begin
            a_q   <= rca_io.a;
            b_q   <= rca_io.b;
            cin_q <= rca_io.cin;
         end
      end
   end
   assign vld    = vld_q;
   assign op_a   = a_q;
   assign op_b   = b_q;
   assign op_cin = cin_q;
`else
   assign vld    = rca_io.in_valid;
   assign op_a   = rca_io.a;
   assign op_b   = rca_io.b;
   assign op_cin = rca_io.cin;
`endif
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   assign c[0] = op_cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]   = op_a[i] ^ op_b[i] ^ c[i];
      assign c[i+1] = (op_a[i] & op_b[i]) | (op_a[i] & c[i]) | (op_b[i] & c[i]);
   end
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             cout_d;
   logic             ovf_q;
   logic             ovf_d;
   always_comb begin
      sum_d  = vld ? s : sum_q;
      cout_d = vld ? c[WIDTH] : cout_q;
      ovf_d  = vld ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= vld;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end
   assign rca_io.out_valid = out_valid_q;
   assign rca_io.sum       = sum_q;
   assign rca_io.cout      = cout_q;
   assign rca_io.ovf       = ovf_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed and randomised checks of 4-bit and 16-bit adders.
module tb_ripple_carry_adder;
`ifdef RCA_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int ND = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   ripple_carry_adder_if #(.WIDTH(4))  if4 ();
   ripple_carry_adder_if #(.WIDTH(16)) if16 ();
   ripple_carry_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .rca_io(if4));
   ripple_carry_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .rca_io(if16));
   always #5 clk = ~clk;
   logic        iv;
   logic [15:0] ia, ib;
   logic        ic;
   logic        p_v, e_v;
   logic [63:0] p4, p16, e4, e16;
   logic [3:0]  da [ND] = '{4'h0, 4'h1, 4'h2, 4'h1, 4'hF, 4'hF, 4'h7, 4'h8};
   logic [3:0]  db [ND] = '{4'h0, 4'h1, 4'h3, 4'h6, 4'h1, 4'hF, 4'h1, 4'h8};
   logic        dc [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   // {ovf, cout, sum}
   logic [5:0]  dexp [ND] = '{6'b000000, 6'b000010, 6'b000101, 6'b000111,
                              6'b010000, 6'b011111, 6'b101000, 6'b110000};
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   // Returns {ovf, cout, sum} for a w-bit add, derived from integer arithmetic.
   function automatic logic [63:0] model(int w, logic [31:0] a, logic [31:0] b, logic c);
      longint lim, u, sa, sb, sr;
      lim = longint'(1) << (w - 1);
      u   = longint'(a) + longint'(b) + longint'(c);
      sa  = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
      sb  = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
      sr  = sa + sb + longint'(c);
      return 64'(u) | ((sr >= lim || sr < -lim) ? (64'd1 << (w + 1)) : 64'd0);
   endfunction
   task automatic drive(logic v, logic [15:0] a, logic [15:0] b, logic c);
      iv = v;
      ia = a;
      ib = b;
      ic = c;
      if4.in_valid  = v;
      if16.in_valid = v;
      if4.a   = v ? a[3:0] : 4'bx;
      if4.b   = v ? b[3:0] : 4'bx;
      if4.cin = v ? c : 1'bx;
      if16.a   = v ? a : 16'bx;
      if16.b   = v ? b : 16'bx;
      if16.cin = v ? c : 1'bx;
   endtask
   task automatic model_reset();
      p_v = 1'b0;
      e_v = 1'b0;
      p4  = '0;
      p16 = '0;
      e4  = '0;
      e16 = '0;
   endtask
   task automatic tick();
      logic        nv;
      logic [63:0] n4, n16, t4, t16;
      @(posedge clk);
      n4  = '0;
      n16 = '0;
      if (iv) begin
         n4  = model(4, 32'(ia[3:0]), 32'(ib[3:0]), ic);
         n16 = model(16, 32'(ia), 32'(ib), ic);
      end
      if (LAT == 2) begin
         nv  = p_v;
         t4  = p4;
         t16 = p16;
         p_v = iv;
         if (iv) begin
            p4  = n4;
            p16 = n16;
         end
      end else begin
         nv  = iv;
         t4  = n4;
         t16 = n16;
      end
      e_v = nv;
      if (nv) begin
         e4  = t4;
         e16 = t16;
      end
      #1;
      check("v4", 64'(if4.out_valid), 64'(e_v));
      check("r4", 64'({if4.ovf, if4.cout, if4.sum}), e4);
      check("v16", 64'(if16.out_valid), 64'(e_v));
      check("r16", 64'({if16.ovf, if16.cout, if16.sum}), e16);
   endtask
   task automatic check_zero(string tag);
      check({tag, "_v4"}, 64'(if4.out_valid), 64'd0);
      check({tag, "_r4"}, 64'({if4.ovf, if4.cout, if4.sum}), 64'd0);
      check({tag, "_v16"}, 64'(if16.out_valid), 64'd0);
      check({tag, "_r16"}, 64'({if16.ovf, if16.cout, if16.sum}), 64'd0);
   endtask
   initial begin
      model_reset();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_zero("por");
      tick();
      tick();
      #3 rst_n = 1'b1;
      // directed vectors back-to-back, hand-computed results
      for (int k = 0; k < ND + LAT - 1; k++) begin
         if (k < ND) drive(1'b1, 16'(da[k]), 16'(db[k]), dc[k]);
         else drive(1'b0, 16'h0, 16'h0, 1'b0);
         tick();
         if (k >= LAT - 1) begin
            check("dir_v", 64'(if4.out_valid), 64'd1);
            check("dir_r", 64'({if4.ovf, if4.cout, if4.sum}), 64'(dexp[k-LAT+1]));
         end
      end
      // hold with toggling operands
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
         tick();
         check("hold_v", 64'(if4.out_valid), 64'd0);
         check("hold_r", 64'({if4.ovf, if4.cout, if4.sum}), 64'(6'b110000));
      end
      // async reset mid-cycle with stale outputs
      drive(1'b1, 16'h0005, 16'h0006, 1'b1);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_zero("arst");
      #2 rst_n = 1'b1;
      tick();
      // exhaustive 4-bit space, upper 16-bit operand bits random
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               drive(1'b1, {12'($urandom), 4'(a)}, {12'($urandom), 4'(b)}, 1'(c));
               tick();
            end
      // random traffic with idle gaps
      for (int k = 0; k < 10000; k++) begin
         drive(1'($urandom_range(0, 9) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
         tick();
      end
      // reset while a valid input is in flight
      drive(1'b1, 16'h1234, 16'h4321, 1'b0);
      tick();
      drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_zero("mid");
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_quiet", 64'(if4.out_valid), 64'd0);
      end
      drive(1'b1, 16'h0003, 16'h0004, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      for (int k = 1; k < LAT; k++) tick();
      check("mid_new_v", 64'(if4.out_valid), 64'd1);
      check("mid_new_r", 64'({if4.ovf, if4.cout, if4.sum}), 64'(6'b000111));
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
